// File: rtl/hamming_minmax_engine.sv
// hamming_minmax_engine
// Responds to a req rising edge by copying N_WORDS 16-bit operands from the
// shared data memory into a local cache, scanning every unordered pair (j<k)
// for the minimum and maximum Hamming distance, and writing min to RES_ADDR
// and max to RES_ADDR+1 before raising done.
// Optional build macro HAM_PAIR_INDEX_EN: also records the (j,k) indices of
// the first min pair and first max pair and writes them to RES_ADDR+2..+5.
// All memory-side outputs are registered; outside a run the bus is held at
// address 0 with the write strobe low.

module hamming_minmax_engine #(
   parameter int N_WORDS   = 32,
   parameter int BASE_ADDR = 0,
   parameter int RES_ADDR  = 64,
   parameter int AW        = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   output logic          done,
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rd_data,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wr_data
);

   localparam int IW = $clog2(N_WORDS);
   localparam int CW = $clog2(2 * N_WORDS);

   localparam logic [IW-1:0] LAST_IDX  = IW'(N_WORDS - 1);
   localparam logic [IW-1:0] LAST_J    = IW'(N_WORDS - 2);
   localparam logic [CW-1:0] LAST_BYTE = CW'(2 * N_WORDS - 1);
   localparam logic [AW-1:0] BASE_A    = AW'(BASE_ADDR);
   localparam logic [AW-1:0] RES_A     = AW'(RES_ADDR);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LOAD    = 4'd1,
      S_COMPARE = 4'd2,
      S_WR_MIN  = 4'd3,
      S_WR_MAX  = 4'd4,
      S_WR_MINJ = 4'd5,
      S_WR_MINK = 4'd6,
      S_WR_MAXJ = 4'd7,
      S_WR_MAXK = 4'd8
   } state_e;

`ifdef HAM_PAIR_INDEX_EN
   localparam state_e LAST_WR = S_WR_MAXK;
`else
   localparam state_e LAST_WR = S_WR_MAX;
`endif

   // Number of set bits in a 16-bit word; result range 0..16.
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] acc;
      acc = 5'd0;
      for (int b = 0; b < 16; b++) begin
         acc = acc + {4'd0, v[b]};
      end
      return acc;
   endfunction

   // Control state
   state_e          state_q, state_d;
   logic            req_q;
   logic            start_s;

   // Registered outputs
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic            wr_en_q, wr_en_d;
   logic [7:0]      wr_data_q, wr_data_d;

   // Datapath
   logic [15:0]     cache_q [N_WORDS];
   logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [CW-2:0]   word_idx_s;
   logic [IW-1:0]   j_q, j_d;
   logic [IW-1:0]   k_q, k_d;
   logic [4:0]      min_q, min_d;
   logic [4:0]      max_q, max_d;
   logic [4:0]      dist_s;
   logic            last_pair_s;

`ifdef HAM_PAIR_INDEX_EN
   logic [IW-1:0]   minj_q, minj_d;
   logic [IW-1:0]   mink_q, mink_d;
   logic [IW-1:0]   maxj_q, maxj_d;
   logic [IW-1:0]   maxk_q, maxk_d;
`endif

   // A run starts only from IDLE on a fresh rising edge of req.
   assign start_s     = (state_q == S_IDLE) && req && !req_q;
   assign word_idx_s  = byte_cnt_q[CW-1:1];
   assign dist_s      = popcount16(cache_q[j_q] ^ cache_q[k_q]);
   assign last_pair_s = (j_q == LAST_J) && (k_q == LAST_IDX);

   assign done        = done_q;
   assign busy        = busy_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_wr_data = wr_data_q;

   // State register and registered copy of req for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req;
      end
   end

   // Next-state sequencing: IDLE -> LOAD -> COMPARE -> result writes -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (byte_cnt_q == LAST_BYTE) begin
               state_d = S_COMPARE;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_COMPARE: begin
            if (last_pair_s) begin
               state_d = S_WR_MIN;
            end else begin
               state_d = S_COMPARE;
            end
         end
         S_WR_MIN: state_d = S_WR_MAX;
`ifdef HAM_PAIR_INDEX_EN
         S_WR_MAX:  state_d = S_WR_MINJ;
         S_WR_MINJ: state_d = S_WR_MINK;
         S_WR_MINK: state_d = S_WR_MAXJ;
         S_WR_MAXJ: state_d = S_WR_MAXK;
         S_WR_MAXK: state_d = S_IDLE;
`else
         S_WR_MAX:  state_d = S_IDLE;
`endif
         default:   state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs, decoded from the state being entered
   // so the bus is already valid during the first cycle of each state.
   always_comb begin
      wr_en_d    = 1'b0;
      mem_addr_d = {AW{1'b0}};
      wr_data_d  = 8'h00;
      busy_d     = (state_d != S_IDLE);
      if (start_s) begin
         done_d = 1'b0;
      end else if (state_q == LAST_WR) begin
         done_d = 1'b1;
      end else begin
         done_d = done_q;
      end
      case (state_d)
         S_LOAD: begin
            mem_addr_d = BASE_A + AW'(byte_cnt_d);
         end
         S_WR_MIN: begin
            wr_en_d    = 1'b1;
            mem_addr_d = RES_A;
            wr_data_d  = {3'b000, min_d};
         end
         S_WR_MAX: begin
            wr_en_d    = 1'b1;
            mem_addr_d = RES_A + AW'(1);
            wr_data_d  = {3'b000, max_d};
         end
`ifdef HAM_PAIR_INDEX_EN
         S_WR_MINJ: begin
            wr_en_d    = 1'b1;
            mem_addr_d = RES_A + AW'(2);
            wr_data_d  = 8'(minj_d);
         end
         S_WR_MINK: begin
            wr_en_d    = 1'b1;
            mem_addr_d = RES_A + AW'(3);
            wr_data_d  = 8'(mink_d);
         end
         S_WR_MAXJ: begin
            wr_en_d    = 1'b1;
            mem_addr_d = RES_A + AW'(4);
            wr_data_d  = 8'(maxj_d);
         end
         S_WR_MAXK: begin
            wr_en_d    = 1'b1;
            mem_addr_d = RES_A + AW'(5);
            wr_data_d  = 8'(maxk_d);
         end
`endif
         default: begin
            wr_en_d    = 1'b0;
            mem_addr_d = {AW{1'b0}};
            wr_data_d  = 8'h00;
         end
      endcase
   end

   // Output registers; reset leaves the bus neutral and done low.
   always_ff @(posedge clk) begin
      if (reset) begin
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         mem_addr_q <= {AW{1'b0}};
         wr_en_q    <= 1'b0;
         wr_data_q  <= 8'h00;
      end else begin
         done_q     <= done_d;
         busy_q     <= busy_d;
         mem_addr_q <= mem_addr_d;
         wr_en_q    <= wr_en_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Datapath next values: load counter, pair walk and strict min/max update.
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      j_d        = j_q;
      k_d        = k_q;
      min_d      = min_q;
      max_d      = max_q;
`ifdef HAM_PAIR_INDEX_EN
      minj_d     = minj_q;
      mink_d     = mink_q;
      maxj_d     = maxj_q;
      maxk_d     = maxk_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               byte_cnt_d = {CW{1'b0}};
               j_d        = {IW{1'b0}};
               k_d        = IW'(1);
               min_d      = 5'd16;
               max_d      = 5'd0;
`ifdef HAM_PAIR_INDEX_EN
               minj_d     = {IW{1'b0}};
               mink_d     = {IW{1'b0}};
               maxj_d     = {IW{1'b0}};
               maxk_d     = {IW{1'b0}};
`endif
            end else begin
               byte_cnt_d = byte_cnt_q;
            end
         end
         S_LOAD: begin
            byte_cnt_d = byte_cnt_q + CW'(1);
         end
         S_COMPARE: begin
            // Strict compares keep the earliest pair on ties.
            if (dist_s < min_q) begin
               min_d = dist_s;
`ifdef HAM_PAIR_INDEX_EN
               minj_d = j_q;
               mink_d = k_q;
`endif
            end else begin
               min_d = min_q;
            end
            if (dist_s > max_q) begin
               max_d = dist_s;
`ifdef HAM_PAIR_INDEX_EN
               maxj_d = j_q;
               maxk_d = k_q;
`endif
            end else begin
               max_d = max_q;
            end
            // Walk k to the end of the row, then start the next row at j+1.
            if (k_q == LAST_IDX) begin
               j_d = j_q + IW'(1);
               k_d = j_q + IW'(2);
            end else begin
               k_d = k_q + IW'(1);
            end
         end
         default: begin
            byte_cnt_d = byte_cnt_q;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt_q <= {CW{1'b0}};
         j_q        <= {IW{1'b0}};
         k_q        <= {IW{1'b0}};
         min_q      <= 5'd16;
         max_q      <= 5'd0;
`ifdef HAM_PAIR_INDEX_EN
         minj_q     <= {IW{1'b0}};
         mink_q     <= {IW{1'b0}};
         maxj_q     <= {IW{1'b0}};
         maxk_q     <= {IW{1'b0}};
`endif
      end else begin
         byte_cnt_q <= byte_cnt_d;
         j_q        <= j_d;
         k_q        <= k_d;
         min_q      <= min_d;
         max_q      <= max_d;
`ifdef HAM_PAIR_INDEX_EN
         minj_q     <= minj_d;
         mink_q     <= mink_d;
         maxj_q     <= maxj_d;
         maxk_q     <= maxk_d;
`endif
      end
   end

   // Operand cache fill: even byte is the high half, odd byte the low half.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < N_WORDS; w++) begin
            cache_q[w] <= 16'h0000;
         end
      end else if (state_q == S_LOAD) begin
         if (byte_cnt_q[0] == 1'b0) begin
            cache_q[word_idx_s][15:8] <= mem_rd_data;
         end else begin
            cache_q[word_idx_s][7:0] <= mem_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_hamming_minmax_engine.sv
// Testbench for hamming_minmax_engine: directed scenarios plus random operand
// sets, checked against a pairwise reference computed with $countones.
// Build with +define+HAM_PAIR_INDEX_EN to also check the pair-index bytes.

module tb_hamming_minmax_engine;

`ifdef HAM_PAIR_INDEX_EN
   localparam int EXP_LAT  = 566;
   localparam int EXP_WR   = 6;
   localparam int LAST_RES = 69;
`else
   localparam int EXP_LAT  = 562;
   localparam int EXP_WR   = 2;
   localparam int LAST_RES = 65;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       req;
   logic       done;
   logic       busy;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;

   logic [15:0] words [32];
   logic [7:0]  opmem [64];
   logic [7:0]  resmem [256];
   logic        clear_req = 1'b0;
   int          wr_count = 0;
   int          stray_wr = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   hamming_minmax_engine dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .done        (done),
      .busy        (busy),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data)
   );

   // Operand bytes live in opmem, everything else in resmem.
   assign mem_rd_data = (mem_addr < 8'd64) ? opmem[mem_addr[5:0]] : resmem[mem_addr];

   // Memory write port, write accounting and result-byte preset.
   always @(posedge clk) begin
      if (clear_req) begin
         resmem[64] <= 8'd16;
         resmem[65] <= 8'd0;
         for (int a = 66; a < 72; a++) resmem[a] <= 8'hEE;
      end else if (mem_wr_en === 1'b1) begin
         wr_count <= wr_count + 1;
         if (mem_addr < 8'd64 || int'(mem_addr) > LAST_RES) stray_wr <= stray_wr + 1;
         if (mem_addr >= 8'd64) resmem[mem_addr] <= mem_wr_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic load_words();
      for (int i = 0; i < 32; i++) begin
         opmem[2*i]   = words[i][15:8];
         opmem[2*i+1] = words[i][7:0];
      end
   endtask

   task automatic preset_results();
      @(negedge clk); clear_req = 1'b1;
      @(negedge clk); clear_req = 1'b0;
   endtask

   // Reference: scan all pairs j<k in order, strict compares keep first winner.
   task automatic model(output int mn, output int mx, output int mnj, output int mnk,
                        output int mxj, output int mxk);
      int d;
      mn = 16; mx = 0; mnj = 0; mnk = 0; mxj = 0; mxk = 0;
      for (int j = 0; j < 31; j++) begin
         for (int k = j + 1; k < 32; k++) begin
            d = $countones(words[j] ^ words[k]);
            if (d < mn) begin mn = d; mnj = j; mnk = k; end
            if (d > mx) begin mx = d; mxj = j; mxk = k; end
         end
      end
   endtask

   task automatic check_results(input string tag);
      int mn, mx, mnj, mnk, mxj, mxk;
      model(mn, mx, mnj, mnk, mxj, mxk);
      check({tag, "_min"}, resmem[64], mn);
      check({tag, "_max"}, resmem[65], mx);
`ifdef HAM_PAIR_INDEX_EN
      check({tag, "_minj"}, resmem[66], mnj);
      check({tag, "_mink"}, resmem[67], mnk);
      check({tag, "_maxj"}, resmem[68], mxj);
      check({tag, "_maxk"}, resmem[69], mxk);
`else
      check({tag, "_b66_untouched"}, resmem[66], 8'hEE);
`endif
   endtask

   // Raise req, measure done latency from the sampling edge, check results.
   // glitch > 0 drops and re-raises req mid-run at that cycle.
   task automatic do_run(input string tag, input int glitch);
      int  lat;
      int  wr_base;
      int  stray_base;
      bit  seen;
      wr_base    = wr_count;
      stray_base = stray_wr;
      @(negedge clk); req = 1'b1;
      @(posedge clk); #1;
      check({tag, "_done_clr"}, done, 1'b0);
      check({tag, "_busy"}, busy, 1'b1);
      seen = 1'b0; lat = 0;
      for (int c = 1; c <= 1000 && !seen; c++) begin
         @(posedge clk); #1;
         if (glitch > 0 && c == glitch) req = 1'b0;
         if (glitch > 0 && c == glitch + 4) req = 1'b1;
         if (done === 1'b1) begin seen = 1'b1; lat = c; end
      end
      check({tag, "_latency"}, lat, EXP_LAT);
      check({tag, "_writes"}, wr_count - wr_base, EXP_WR);
      check({tag, "_stray"}, stray_wr - stray_base, 0);
      check_results(tag);
   endtask

   task automatic drop_req();
      @(negedge clk); req = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req   = 1'b0;
      for (int i = 0; i < 32; i++) words[i] = 16'h0000;
      load_words();
      preset_results();
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_en", mem_wr_en, 1'b0);
      check("rst_addr", mem_addr, 8'd0);
      check("rst_wdata", mem_wr_data, 8'd0);
      @(negedge clk); reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_addr", mem_addr, 8'd0);

      // All-zero operands.
      do_run("zeros", 0);
      drop_req();

      // Alternating pattern with one inverted word.
      for (int i = 0; i < 32; i++) words[i] = 16'hAAAA;
      words[5] = 16'h5555;
      load_words(); preset_results();
      do_run("aaaa", 0);
      drop_req();

      // One-hot walking bit; word i equals word i+16.
      for (int i = 0; i < 32; i++) words[i] = 16'h0001 << (i % 16);
      load_words(); preset_results();
      do_run("onehot", 0);
      drop_req();

      // Random operand sets, some sparse to pull distances down.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 32; i++) begin
            if (r < 2) words[i] = 16'($urandom);
            else       words[i] = 16'($urandom) & 16'($urandom) & 16'($urandom);
         end
         load_words(); preset_results();
         do_run($sformatf("rand%0d", r), 0);
         drop_req();
      end

      // Reset during COMPARE: no writes, results untouched, then a clean rerun.
      for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
      load_words(); preset_results();
      @(negedge clk); req = 1'b1;
      @(posedge clk); #1;
      begin
         int wr_base;
         wr_base = wr_count;
         repeat (64 + 200) @(posedge clk);
         @(negedge clk); reset = 1'b1; req = 1'b0;
         @(posedge clk); #1;
         check("abort_done", done, 1'b0);
         check("abort_busy", busy, 1'b0);
         check("abort_wr_en", mem_wr_en, 1'b0);
         @(negedge clk); reset = 1'b0;
         repeat (700) @(posedge clk);
         #1;
         check("abort_b64", resmem[64], 8'd16);
         check("abort_b65", resmem[65], 8'd0);
         check("abort_writes", wr_count - wr_base, 0);
         check("abort_done_idle", done, 1'b0);
      end
      do_run("after_abort", 0);

      // req held high past completion: exactly one run, done stays high.
      drop_req();
      for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
      load_words(); preset_results();
      do_run("held", 0);
      begin
         int wr_base;
         wr_base = wr_count;
         repeat (700) @(posedge clk);
         #1;
         check("held_done", done, 1'b1);
         check("held_busy", busy, 1'b0);
         check("held_no_rerun", wr_count - wr_base, 0);
      end

      // Drop and re-raise: second run, with a req rise mid-run ignored.
      drop_req();
      do_run("second", 300);
      begin
         int wr_base;
         wr_base = wr_count;
         repeat (50) @(posedge clk);
         #1;
         check("second_idle_busy", busy, 1'b0);
         check("second_idle_done", done, 1'b1);
         check("second_no_rerun", wr_count - wr_base, 0);
      end

      check("stray_total", stray_wr, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
